// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: hex glyph table, scan-decoder state codes
// and small helpers for the active-low anode bus.
package sevenseg_pkg;

    // Active-high {g,f,e,d,c,b,a} glyphs for 0..F; index 15 sits in the top slice.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    function automatic logic onehot_low(input logic [3:0] an);
        logic [3:0] a;
        a = ~an;
        return (a != 4'h0) && ((a & (a - 4'd1)) == 4'h0);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational glyph decoder: raw active-low cathode pattern -> hex value,
// blank flag and a hit flag (pattern is a known glyph or fully blank).
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_raw_i,
    output logic       hit_o,
    output logic [3:0] value_o,
    output logic       blank_o
);

    always_comb begin
        hit_o   = 1'b0;
        value_o = 4'h0;
        blank_o = 1'b0;
        if (seg_raw_i == 7'h7F) begin
            hit_o   = 1'b1;
            blank_o = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (~seg_raw_i == SEG_HEX[i]) begin
                    hit_o   = 1'b1;
                    value_o = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Monitors a multiplexed 4-digit seven-segment bus, filters scan-transition
// bleeding and publishes coherent frames of digits, decimal points and blanks.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        i_w_clk,
    input  logic        i_w_reset_n,
    input  logic [3:0]  i_w_AN,
    input  logic [6:0]  i_w_SEG,
    input  logic        i_w_DP,
    output logic [15:0] o_r_digits,
    output logic [3:0]  o_r_dp,
    output logic [3:0]  o_r_blank,
    output logic        o_r_frameValid,
    output logic        o_r_segError,
    output logic        o_r_stale
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [11:0]      sync1_q, sync2_q, ref_q;
    logic [1:0]       state_q;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q;
    logic [3:0][3:0]  shd_digit_q;
    logic [3:0]       shd_dp_q, shd_blank_q, seen_q, seen_d, cap_bit;
    logic             frame_pend_q;
    logic [15:0]      digits_q;
    logic [3:0]       dp_q, blank_q;
    logic             frame_q;

    logic             one_low, capture, dec_hit, dec_blank;
    logic [3:0]       dec_value;
    logic [1:0]       slot;

    assign one_low = onehot_low(sync2_q[11:8]);
    assign capture = (state_q == CAPTURE);
    assign slot    = an_index(ref_q[11:8]);
    assign cap_bit = capture ? (4'b0001 << slot) : 4'b0000;
    assign cnt_d   = (cnt_q == SW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    // A frame publish clears seen; a capture in the same cycle lands after the clear.
    assign seen_d  = (frame_pend_q ? 4'h0 : seen_q) | cap_bit;

    sevenseg_pattern_decode u_decode (
        .seg_raw_i (ref_q[7:1]),
        .hit_o     (dec_hit),
        .value_o   (dec_value),
        .blank_o   (dec_blank)
    );

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ref_q   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {i_w_AN, i_w_SEG, i_w_DP};
            sync2_q <= sync1_q;
            case (state_q)
                IDLE: if (one_low) begin
                    state_q <= SETTLE;
                    ref_q   <= sync2_q;
                    cnt_q   <= SW'(1);
                end
                SETTLE: if (!one_low) begin
                    state_q <= IDLE;
                end else if (sync2_q != ref_q) begin
                    ref_q <= sync2_q;
                    cnt_q <= SW'(1);
                end else begin
                    cnt_q <= cnt_d;
                    if (cnt_d == SW'(STABLE_CYCLES)) state_q <= CAPTURE;
                end
                CAPTURE: state_q <= HOLD;
                // Leaving through IDLE keeps one scan step from being captured twice.
                HOLD: if (sync2_q != ref_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            tmo_q        <= '0;
            shd_digit_q  <= '0;
            shd_dp_q     <= '0;
            shd_blank_q  <= '0;
            seen_q       <= '0;
            frame_pend_q <= 1'b0;
            digits_q     <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            frame_q      <= 1'b0;
        end else begin
            if (capture)
                tmo_q <= '0;
            else if (tmo_q != TW'(TIMEOUT_CYCLES))
                tmo_q <= tmo_q + 1'b1;

            if (capture) begin
                shd_dp_q[slot] <= ~ref_q[0];
                if (dec_hit) begin
                    shd_digit_q[slot] <= dec_value;
                    shd_blank_q[slot] <= dec_blank;
                end
            end
            seen_q       <= seen_d;
            frame_pend_q <= capture && (seen_d == 4'hF);

            frame_q <= frame_pend_q;
            if (frame_pend_q) begin
                digits_q <= shd_digit_q;
                dp_q     <= shd_dp_q;
                blank_q  <= shd_blank_q;
            end
        end
    end

    assign o_r_digits     = digits_q;
    assign o_r_dp         = dp_q;
    assign o_r_blank      = blank_q;
    assign o_r_frameValid = frame_q;
    assign o_r_segError   = capture && !dec_hit;
    assign o_r_stale      = (tmo_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed and randomized scans of the seven-segment bus checked against a
// slot-level model of captures, frames and decode errors.
module tb_sevenseg_scan_decoder;

    localparam int STABLE = 16;
    localparam int TMO    = 300;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic        dp = 1'b1;
    logic [15:0] digits;
    logic [3:0]  odp, oblank;
    logic        fv, serr, stale;

    always #5 clk = ~clk;

    sevenseg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .i_w_clk(clk), .i_w_reset_n(rst_n), .i_w_AN(an), .i_w_SEG(seg), .i_w_DP(dp),
        .o_r_digits(digits), .o_r_dp(odp), .o_r_blank(oblank),
        .o_r_frameValid(fv), .o_r_segError(serr), .o_r_stale(stale)
    );

    int cyc = 0;
    int fv_cnt = 0, err_cnt = 0, fv_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst_n) begin
        if (fv) begin fv_cnt <= fv_cnt + 1; fv_cyc <= cyc; end
        if (serr) err_cnt <= err_cnt + 1;
    end

    // Slot-level reference model
    int          m_frames = 0, m_err = 0;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_dp = '0, m_blank = '0, m_seen = '0;
    logic [15:0] e_digits = '0;
    logic [3:0]  e_dp = '0, e_blank = '0;
    logic [6:0]  last_seg = 7'h7F;
    int tests = 0, fails = 0;
    int fv0, err0, mf0, me0, t0, t_dummy;

    function automatic int lookup(input logic [6:0] raw);
        int r;
        r = -1;
        for (int i = 0; i < 16; i++) if (~raw == HEX[i]) r = i;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_dp = '0; m_blank = '0; m_seen = '0;
        e_digits = '0; e_dp = '0; e_blank = '0;
    endfunction

    function automatic void model_capture(input int k, input logic [6:0] s, input logic d);
        int v;
        m_dp[k] = ~d;
        v = lookup(s);
        if (s == 7'h7F) begin
            m_dig[k] = 4'h0; m_blank[k] = 1'b1;
        end else if (v >= 0) begin
            m_dig[k] = 4'(v); m_blank[k] = 1'b0;
        end else begin
            m_err++;
        end
        m_seen[k] = 1'b1;
        if (m_seen == 4'hF) begin
            m_frames++;
            e_digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            e_dp = m_dp; e_blank = m_blank; m_seen = '0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        an = 4'hF; seg = 7'h7F; dp = 1'b1; last_seg = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_slot(input int k, input logic [6:0] s, input logic d,
                              input int len, input int bleed, output int start);
        logic [6:0] ps;
        ps = last_seg;
        start = cyc;
        for (int i = 0; i < len; i++) begin
            an = ~(4'b0001 << k); seg = (i < bleed) ? ps : s; dp = d;
            @(negedge clk);
        end
        last_seg = s;
        if (len - bleed >= STABLE) model_capture(k, s, d);
    endtask

    task automatic scan(input logic [15:0] v, input logic [3:0] dpl, input int bleed,
                        input int gap_last, output int start0);
        int t;
        start0 = 0;
        for (int k = 3; k >= 0; k--) begin
            if (k == 0 && gap_last > 0) idle(gap_last);
            drive_slot(k, ~HEX[v[k*4 +: 4]], ~dpl[k], 40, bleed, t);
            if (k == 0) start0 = t;
        end
    endtask

    task automatic snap();
        fv0 = fv_cnt; err0 = err_cnt; mf0 = m_frames; me0 = m_err;
    endtask

    task automatic check_frame(input string tag);
        check({tag, " frames"}, 32'(fv_cnt - fv0), 32'(m_frames - mf0));
        check({tag, " segerr"}, 32'(err_cnt - err0), 32'(m_err - me0));
        check({tag, " digits"}, 32'(digits), 32'(e_digits));
        check({tag, " dp"}, 32'(odp), 32'(e_dp));
        check({tag, " blank"}, 32'(oblank), 32'(e_blank));
    endtask

    initial begin
        logic [6:0] r;
        logic [15:0] v;
        model_reset();

        // Reset with a noisy bus
        repeat (20) begin
            @(negedge clk);
            an = 4'($urandom); seg = 7'($urandom); dp = 1'($urandom);
        end
        check("rst digits", 32'(digits), 32'h0);
        check("rst dp_blank", 32'({odp, oblank}), 32'h0);
        check("rst pulses_stale", 32'({fv, serr, stale}), 32'h0);

        // Idle bus: no frames, stale exactly after TMO cycles, then saturates
        idle(1);
        rst_n = 1'b1;
        repeat (TMO - 1) @(negedge clk);
        check("stale before", 32'(stale), 32'h0);
        @(negedge clk);
        check("stale at timeout", 32'(stale), 32'h1);
        repeat (50) @(negedge clk);
        check("stale saturated", 32'(stale), 32'h1);
        check("idle frames", 32'(fv_cnt), 32'h0);

        // Clean "12:34", idle before the last slot so its latency is measured from rest
        snap();
        scan(16'h1234, 4'b0100, 0, 5, t0);
        idle(10);
        check_frame("clean");
        check("clean digits const", 32'(digits), 32'h1234);
        check("clean latency", 32'(fv_cyc - t0), 32'(STABLE + 4));
        check("clean stale", 32'(stale), 32'h0);

        // Bleeding on every anode switch
        snap();
        scan(16'h1234, 4'b0100, 3, 0, t_dummy);
        idle(10);
        check_frame("bleed");

        // Short slot is rejected until a full-length pass
        snap();
        drive_slot(3, ~HEX[9], 1'b1, 40, 0, t_dummy);
        drive_slot(2, ~HEX[10], 1'b1, 40, 0, t_dummy);
        drive_slot(1, ~HEX[11], 1'b1, 40, 0, t_dummy);
        drive_slot(0, ~HEX[12], 1'b1, STABLE - 1, 0, t_dummy);
        idle(30);
        check("glitch no frame", 32'(fv_cnt - fv0), 32'h0);
        check_frame("glitch");
        drive_slot(0, ~HEX[12], 1'b1, 40, 0, t_dummy);
        idle(10);
        check_frame("glitch full");
        check("glitch digits const", 32'(digits), 32'h9ABC);

        // Unknown pattern on digit 1, blank on digit 3
        snap();
        drive_slot(3, 7'h7F, 1'b1, 40, 0, t_dummy);
        drive_slot(2, ~HEX[7], 1'b1, 40, 0, t_dummy);
        drive_slot(1, 7'h36, 1'b1, 40, 0, t_dummy);
        drive_slot(0, ~HEX[14], 1'b0, 40, 0, t_dummy);
        idle(10);
        check_frame("err");
        check("err single pulse", 32'(err_cnt - err0), 32'h1);
        check("err d1 kept", 32'(digits[7:4]), 32'hB);
        check("err blank const", 32'(oblank), 32'b1000);

        // Randomized scans: valid, blank, unknown and too-short slots
        for (int s = 0; s < 8; s++) begin
            snap();
            for (int k = 3; k >= 0; k--) begin
                int kind, len;
                kind = $urandom_range(0, 9);
                len  = $urandom_range(STABLE + 4, 45);
                if (kind == 0) len = STABLE - 1;
                if (kind == 1) r = 7'h7F;
                else if (kind == 2) begin
                    do r = 7'($urandom); while (r == 7'h7F || lookup(r) >= 0);
                end else r = ~HEX[$urandom_range(0, 15)];
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
                drive_slot(k, r, 1'($urandom), len, 0, t_dummy);
            end
            idle(10);
            check_frame("rand");
        end

        // Reset in the middle of a frame, then a fresh "5678"
        snap();
        drive_slot(3, ~HEX[5], 1'b1, 40, 0, t_dummy);
        drive_slot(2, ~HEX[6], 1'b1, 40, 0, t_dummy);
        rst_n = 1'b0;
        repeat (5) begin
            an = 4'($urandom); seg = 7'($urandom); dp = 1'($urandom);
            @(negedge clk);
        end
        check("midrst digits", 32'(digits), 32'h0);
        check("midrst dp_blank_stale", 32'({odp, oblank, stale}), 32'h0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(5);
        snap();
        v = 16'h5678;
        scan(v, 4'b0000, 0, 0, t_dummy);
        idle(10);
        check_frame("after rst");
        check("after rst one frame", 32'(fv_cnt - fv0), 32'h1);
        check("after rst digits const", 32'(digits), 32'h5678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
